// File: rtl/mem_bus_pkg.sv
// Shared definitions for the MAR/MDR memory-access path: default bus geometry
// and the access-controller state encoding.
package mem_bus_pkg;

    localparam int BUS_DATA_W = 32;
    localparam int BUS_ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/reg_n.sv
// Generic W-bit register with load enable and asynchronous active-high clear;
// used for both MAR and MDR.
module reg_n #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] value_d;
    logic [W-1:0] value_q;

    always_comb begin
        value_d = ld ? d : value_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign q = value_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// MAR/MDR memory-access controller: bus-side register loads plus a
// request/acknowledge memory handshake with an optional timeout.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int DATA_W     = BUS_DATA_W,
    parameter int ADDR_W     = BUS_ADDR_W,
    parameter int TIMEOUT    = 15,
    parameter int ADDR_CLAMP = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_ld,
    input  logic              mdr_ld,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mar_q,
    output logic [DATA_W-1:0] mdr_q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    state_e            state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              err_d, err_q;

    logic              accepting;
    logic [ADDR_W-1:0] mar_in;
    logic              mar_en;
    logic [DATA_W-1:0] mdr_in;
    logic              mdr_en;

    // Loads are only honoured between accesses so MAR/MDR stay frozen while strobing.
    assign accepting = (state_q == IDLE) || (state_q == FIN);

    always_comb begin
        if ((ADDR_CLAMP != 0) && ((bus_in >> ADDR_W) != '0)) begin
            mar_in = '1;
        end else begin
            mar_in = bus_in[ADDR_W-1:0];
        end
    end

    assign mar_en = accepting && mar_ld;
    assign mdr_en = (accepting && mdr_ld) || ((state_q == RD) && mem_ack);
    assign mdr_in = (state_q == RD) ? mem_rdata : bus_in;

    reg_n #(.W(ADDR_W)) u_mar (
        .clk (clk),
        .clr (clr),
        .ld  (mar_en),
        .d   (mar_in),
        .q   (mar_q)
    );

    reg_n #(.W(DATA_W)) u_mdr (
        .clk (clk),
        .clr (clr),
        .ld  (mdr_en),
        .d   (mdr_in),
        .q   (mdr_q)
    );

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rd_req && wr_req) begin
                    state_d = FIN;
                    err_d   = 1'b1;
                end else if (rd_req) begin
                    state_d = RD;
                end else if (wr_req) begin
                    state_d = WR;
                end
            end
            RD, WR: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    state_d = FIN;
                end else if ((TIMEOUT != 0) && (cnt_inc == CNT_LIMIT)) begin
                    state_d = FIN;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
    assign mem_re    = (state_q == RD);
    assign mem_we    = (state_q == WR);
    assign busy      = (state_q == RD) || (state_q == WR);
    assign done      = (state_q == FIN);
    assign err       = err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl; a second instance with
// address truncation covers the non-clamping address path.
module tb_mem_bus_ctrl;

    logic        clk;
    logic        clr;
    logic [31:0] busIn;
    logic        marLd;
    logic        mdrLd;
    logic        rdReq;
    logic        wrReq;
    logic [31:0] memRdata;
    logic        memAck;

    logic [8:0]  memAddr,  memAddr2;
    logic [31:0] memWdata, memWdata2;
    logic        memRe,    memRe2;
    logic        memWe,    memWe2;
    logic [8:0]  marQ,     marQ2;
    logic [31:0] mdrQ,     mdrQ2;
    logic        busy,     busy2;
    logic        done,     done2;
    logic        err,      err2;

    int testCount = 0;
    int failCount = 0;
    int strobeCount;
    int guard;

    mem_bus_ctrl #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(4), .ADDR_CLAMP(1)) dut (
        .clk(clk), .clr(clr), .bus_in(busIn), .mar_ld(marLd), .mdr_ld(mdrLd),
        .rd_req(rdReq), .wr_req(wrReq), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_re(memRe), .mem_we(memWe), .mem_rdata(memRdata), .mem_ack(memAck),
        .mar_q(marQ), .mdr_q(mdrQ), .busy(busy), .done(done), .err(err)
    );

    mem_bus_ctrl #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(4), .ADDR_CLAMP(0)) dutTrunc (
        .clk(clk), .clr(clr), .bus_in(busIn), .mar_ld(marLd), .mdr_ld(mdrLd),
        .rd_req(rdReq), .wr_req(wrReq), .mem_addr(memAddr2), .mem_wdata(memWdata2),
        .mem_re(memRe2), .mem_we(memWe2), .mem_rdata(memRdata), .mem_ack(memAck),
        .mar_q(marQ2), .mdr_q(mdrQ2), .busy(busy2), .done(done2), .err(err2)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one cycle of inputs, lets a rising edge pass, then drops all
    // one-shot controls; outputs are stable for checking on return.
    task automatic applyStimulus(input logic [31:0] bus, input logic ml, input logic dl,
                                 input logic rq, input logic wq, input logic ack,
                                 input logic [31:0] rdata);
        busIn    = bus;
        marLd    = ml;
        mdrLd    = dl;
        rdReq    = rq;
        wrReq    = wq;
        memAck   = ack;
        memRdata = rdata;
        @(posedge clk);
        #1;
        marLd  = 1'b0;
        mdrLd  = 1'b0;
        rdReq  = 1'b0;
        wrReq  = 1'b0;
        memAck = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Main directed sequence.
    initial begin
        clr = 1'b1; busIn = '0; marLd = 0; mdrLd = 0; rdReq = 0; wrReq = 0;
        memAck = 0; memRdata = '0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("reset_mar", 32'(marQ), 32'h0);
        checkOutput("reset_mdr", mdrQ, 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);

        // Zero-wait read at 0x25.
        applyStimulus(32'h25, 1, 0, 0, 0, 0, 32'h0);
        checkOutput("rd_mem_addr", 32'(memAddr), 32'h025);
        applyStimulus(32'h0, 0, 0, 1, 0, 0, 32'h0);
        checkOutput("rd_mem_re", 32'(memRe), 32'h1);
        checkOutput("rd_busy", 32'(busy), 32'h1);
        checkOutput("rd_done_early", 32'(done), 32'h0);
        applyStimulus(32'h0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        checkOutput("rd_done", 32'(done), 32'h1);
        checkOutput("rd_err", 32'(err), 32'h0);
        checkOutput("rd_mdr", mdrQ, 32'hDEADBEEF);
        checkOutput("rd_re_off", 32'(memRe), 32'h0);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("rd_done_pulse", 32'(done), 32'h0);

        // Ack outside an access must not touch MDR.
        applyStimulus(32'h0, 0, 0, 0, 0, 1, 32'h5555AAAA);
        checkOutput("idle_ack_mdr", mdrQ, 32'hDEADBEEF);
        checkOutput("idle_ack_done", 32'(done), 32'h0);

        // Write with load in the request cycle, ack on the third strobe cycle.
        applyStimulus(32'h12345678, 0, 1, 0, 1, 0, 32'h0);
        strobeCount = 0;
        for (int i = 0; i < 3; i++) begin
            if (memWe) strobeCount++;
            checkOutput("wr_wdata", memWdata, 32'h12345678);
            applyStimulus(32'h0, 0, 0, 0, 0, (i == 2), 32'hFFFF0000);
        end
        checkOutput("wr_we_cycles", 32'(strobeCount), 32'd3);
        checkOutput("wr_we_off", 32'(memWe), 32'h0);
        checkOutput("wr_done", 32'(done), 32'h1);
        checkOutput("wr_err", 32'(err), 32'h0);
        checkOutput("wr_mdr", mdrQ, 32'h12345678);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 32'h0);

        // Read with no ack times out after four strobe cycles.
        applyStimulus(32'h0, 0, 0, 1, 0, 0, 32'h0);
        strobeCount = 0;
        guard = 0;
        while (!done && guard < 10) begin
            if (memRe) strobeCount++;
            applyStimulus(32'h0, 0, 0, 0, 0, 0, 32'hFFFFFFFF);
            guard++;
        end
        checkOutput("to_re_cycles", 32'(strobeCount), 32'd4);
        checkOutput("to_done", 32'(done), 32'h1);
        checkOutput("to_err", 32'(err), 32'h1);
        checkOutput("to_mdr", mdrQ, 32'h12345678);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("to_idle_busy", 32'(busy), 32'h0);
        checkOutput("to_idle_err", 32'(err), 32'h0);

        // Simultaneous read and write requests.
        applyStimulus(32'h0, 0, 0, 1, 1, 0, 32'h0);
        checkOutput("cf_done", 32'(done), 32'h1);
        checkOutput("cf_err", 32'(err), 32'h1);
        checkOutput("cf_strobes", 32'({memRe, memWe}), 32'h0);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("cf_done_pulse", 32'(done), 32'h0);

        // Loads and requests during a read are ignored; loads in FIN are taken.
        applyStimulus(32'h0, 0, 0, 1, 0, 0, 32'h0);
        applyStimulus(32'hAAAA, 1, 1, 1, 0, 0, 32'h0);
        checkOutput("ig_mar", 32'(marQ), 32'h025);
        checkOutput("ig_mdr", mdrQ, 32'h12345678);
        checkOutput("ig_re", 32'(memRe), 32'h1);
        applyStimulus(32'h0, 0, 0, 0, 0, 1, 32'h0BADF00D);
        checkOutput("ig_done", 32'(done), 32'h1);
        checkOutput("ig_mdr_rd", mdrQ, 32'h0BADF00D);
        applyStimulus(32'h1C3, 1, 0, 1, 0, 0, 32'h0);
        checkOutput("fin_mar_ld", 32'(marQ), 32'h1C3);
        checkOutput("fin_req_ign", 32'({busy, done}), 32'h0);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("fin_single_done", 32'({memRe, done}), 32'h0);

        // Address clamp versus truncation.
        applyStimulus(32'h00000400, 1, 0, 0, 0, 0, 32'h0);
        checkOutput("clamp_sat", 32'(marQ), 32'h1FF);
        checkOutput("clamp_trunc", 32'(marQ2), 32'h000);
        applyStimulus(32'h00000605, 1, 0, 0, 0, 0, 32'h0);
        checkOutput("clamp_sat2", 32'(marQ), 32'h1FF);
        checkOutput("clamp_trunc2", 32'(marQ2), 32'h005);
        applyStimulus(32'h000001FE, 1, 0, 0, 0, 0, 32'h0);
        checkOutput("clamp_inrange", 32'(marQ), 32'h1FE);

        // Asynchronous clear in the middle of a read.
        applyStimulus(32'h0, 0, 0, 1, 0, 0, 32'h0);
        checkOutput("clr_pre_re", 32'(memRe), 32'h1);
        #2;
        clr = 1'b1;
        #1;
        checkOutput("clr_re", 32'(memRe), 32'h0);
        checkOutput("clr_busy", 32'(busy), 32'h0);
        checkOutput("clr_mar", 32'(marQ), 32'h0);
        checkOutput("clr_mdr", mdrQ, 32'h0);
        applyStimulus(32'h0, 0, 0, 0, 0, 1, 32'h77777777);
        clr = 1'b0;
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("clr_no_done", 32'(done), 32'h0);
        checkOutput("clr_mdr_hold", mdrQ, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Parametrised MAR/MDR memory-access controller for the bus datapath. It replaces the fixed 32-bit MAR/MDR pair and the zero-latency RAM coupling with a width/depth-generic unit. Memory accesses run through a request/acknowledge handshake with a timeout. It sits between the shared bus (BusMuxOut) and an external memory, and exposes MDR contents back to the bus multiplexer.

Parameters:
DATA_W, 32, data/bus width
ADDR_W, 9, memory address width (MAR width)
TIMEOUT, 15, max cycles to wait for mem_ack; 0 = wait forever
ADDR_CLAMP, 1, 1 = saturate out-of-range bus address to 2^ADDR_W-1; 0 = truncate to low ADDR_W bits

Ports:
clk  in  1  system clock, rising edge
clr  in  1  reset, asynchronous, active-high
bus_in  in  DATA_W  value currently on the bus
mar_ld  in  1  load MAR from bus_in
mdr_ld  in  1  load MDR from bus_in
rd_req  in  1  start read of mem[MAR] into MDR
wr_req  in  1  start write of MDR to mem[MAR]
mem_addr  out  ADDR_W  memory address (= mar_q)
mem_wdata  out  DATA_W  memory write data (= mdr_q)
mem_re  out  1  read strobe, held for the whole read
mem_we  out  1  write strobe, held for the whole write
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion
mar_q  out  ADDR_W  MAR contents
mdr_q  out  DATA_W  MDR contents, to bus mux
busy  out  1  access in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse, coincident with done

Behaviour:
- Reset, asynchronous on clr high: state IDLE; mar_q, mdr_q, wait counter = 0; mem_re, mem_we, busy, done, err = 0. Strobes drop immediately, including mid-access. No partial MDR update.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - mar_ld loads MAR. With ADDR_CLAMP=1, a bus_in value above 2^ADDR_W-1 saturates to all-ones; otherwise the low ADDR_W bits are taken.
  - mdr_ld loads MDR.
  - Both loads in the same cycle are permitted.
  - rd_req alone -> RD. wr_req alone -> WR.
  - rd_req and wr_req together -> FIN with err; no strobe is issued.
  - A load and a request in the same cycle: the load takes effect first, so the access uses the new MAR/MDR value.
- RD:
  - mem_re=1 and busy=1. Counter clears on entry and increments each cycle.
  - mem_ack sampled high: MDR <= mem_rdata, -> FIN (no err).
  - Counter reaches TIMEOUT with no ack: -> FIN with err; MDR unchanged.
- WR: mem_we=1 and busy=1. Same ack/timeout rule as RD; MDR unchanged.
- FIN: done=1 for one cycle (err=1 if the access failed), busy=0, -> IDLE. Requests in FIN are ignored. Loads in FIN are accepted.
- mar_ld, mdr_ld, rd_req and wr_req in RD/WR are ignored. MAR and MDR are frozen during an access.
- mem_ack outside RD/WR is ignored.
- Latency: request in cycle 0, strobe from cycle 1, ack in cycle 1+k, done in cycle 2+k. Minimum request-to-done is 2 cycles.
- Counter width is $clog2(TIMEOUT+1), minimum 1. With TIMEOUT=0 the counter is unused and there is no timeout.
- mem_addr and mem_wdata are driven continuously from the MAR/MDR registers, not gated by the strobes.

Decomposition:
- Package mem_bus_pkg holds:
  - state enum (IDLE, RD, WR, FIN)
  - default DATA_W / ADDR_W constants shared with the bus mux and register file
- Sub-module reg_n: parametrised-width register with async active-high clr and load enable, the generic successor of the 32-bit register. Instantiate it twice, for MAR and MDR.
- FSM and counter stay in mem_bus_ctrl.

Test Plan:
- Reset/idle: clr pulse mid-RD with mem_re=1 -> mem_re drops same cycle; mar_q=0, mdr_q=0, busy=0, no done.
- Read, zero wait: bus_in=0x25, mar_ld; then rd_req; memory acks on first strobe cycle with 0xDEADBEEF -> mem_addr=0x025, done 2 cycles after rd_req, mdr_q=0xDEADBEEF, err=0.
- Write with wait states: mdr_ld 0x12345678 plus wr_req in the same cycle; ack after 3 strobe cycles -> mem_wdata=0x12345678 throughout, mem_we high exactly 3 cycles, done pulse.
- Timeout (TIMEOUT=4): rd_req, no ack -> after 4 strobe cycles done=err=1, mdr_q unchanged, back to IDLE.
- Clamp: ADDR_CLAMP=1, bus_in=0x00000400 with mar_ld -> mar_q=0x1FF. Rerun with ADDR_CLAMP=0 -> mar_q=0x000.
- Conflict/ignore: rd_req and wr_req together -> no strobe, done=err=1 next cycle. During a read, mdr_ld 0xAAAA and a second rd_req -> both ignored, single done.
